bcd_serial_add_ctrl: RTL and testbench

- Sequencer that performs a DIGITS-wide packed-BCD addition using one shared single-digit BCD adder, processing one digit per clock from LSD to MSD.
- Captures operands on start, drives the digit adder's a/b/cin each cycle, and ripples the digit carry through a register.
- Assembles the result and reports done/err.
- Sits between a host (register bank or keypad/display logic) and the combinational digit adder instance.

---
 rtl/bcd_serial_add_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
// -------------------
// Sequencer for a DIGITS-wide packed-BCD addition built around one external
// combinational single-digit BCD adder. Operands are captured on start, then
// one digit per clock is presented to the digit adder, from the least
// significant digit to the most significant digit. The decimal carry ripples
// through a register. When the last digit has been added, the assembled
// result is published together with a one-cycle done pulse.
//
// Optional feature (macro BCD_SUB_EN):
//   This macro adds the input 'sub'. When sub=1, the block computes A-B. Each
//   B digit is replaced by its nines complement, and the initial carry is
//   forced to 1. With BCD_SUB_EN undefined, the block only adds.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, accepted only while idle
//   a, b      in   packed BCD operands, digit 0 in bits [3:0]
//   cin       in   carry into digit 0
//   sub       in   (BCD_SUB_EN only) subtract B from A
//   dig_a     out  digit adder A nibble
//   dig_b     out  digit adder B nibble
//   dig_cin   out  digit adder carry in
//   dig_sum   in   digit adder sum, same cycle
//   dig_cout  in   digit adder carry out, same cycle
//   busy      out  operation in progress (RUN and DONE)
//   done      out  one-cycle pulse, sum/cout valid
//   sum       out  packed BCD result, held until the next done
//   cout      out  final decimal carry, held until the next done
//   err       out  a captured operand nibble was above 9, held until next start

module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
`ifdef BCD_SUB_EN
    input  logic                  sub,
`endif
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_sum,
    input  logic                  dig_cout,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic           carry;
    logic [CW-1:0]  k;
    logic [W-1:0]   res;
    logic [W-1:0]   res_next;
    logic [W-1:0]   b_load;
    logic           cin_load;

    // True when any nibble of v is not a valid decimal digit.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

`ifdef BCD_SUB_EN
    // Nines complement of every digit. An invalid digit wraps modulo 16. The
    // result for such a digit does not matter, because err already flags it.
    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

    // Subtraction is A + nines(B) + 1. The complement is applied once at
    // capture, so the RUN datapath is the same for add and subtract.
    assign b_load   = sub ? nines(b) : b;
    assign cin_load = sub ? 1'b1 : cin;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    // Operands are kept in shift registers. The current digit is always the
    // low nibble, so the digit adder is fed without a wide multiplexer. The
    // carry register holds the captured carry-in for digit 0. After that it
    // holds the previous digit's carry-out.
    assign dig_a   = (state == RUN) ? a_sh[3:0] : 4'd0;
    assign dig_b   = (state == RUN) ? b_sh[3:0] : 4'd0;
    assign dig_cin = (state == RUN) ? carry     : 1'b0;

    // Partial result with the current digit's sum merged in. On the final
    // digit this is the complete result that is loaded into sum.
    always_comb begin
        res_next = res;
        for (int i = 0; i < DIGITS; i++) begin
            if (k == CW'(i)) begin
                res_next[4*i +: 4] = dig_sum;
            end
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            k     <= '0;
            res   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= cin_load;
                        k     <= '0;
                        res   <= '0;
                        err   <= has_bad_digit(a) | has_bad_digit(b);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    res   <= res_next;
                    carry <= dig_cout;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    if (k == LAST_DIGIT) begin
                        sum   <= res_next;
                        cout  <= dig_cout;
                        done  <= 1'b1;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    k     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
// ----------------------
// Directed testbench for bcd_serial_add_ctrl. A 4-digit instance and a
// 1-digit instance are each connected to their own behavioural single-digit
// BCD adder. Each scenario task drives stimulus and checks the outputs against
// hand-computed results.

module tb_bcd_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  dig_a;
    logic [3:0]  dig_b;
    logic        dig_cin;
    logic [3:0]  dig_sum;
    logic        dig_cout;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;
`ifdef BCD_SUB_EN
    logic        sub;
`endif

    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        cin1;
    logic [3:0]  dig1_a;
    logic [3:0]  dig1_b;
    logic        dig1_cin;
    logic [3:0]  dig1_sum;
    logic        dig1_cout;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;
    logic        cout1;
    logic        err1;

    int checks = 0;
    int errors = 0;

    // Values observed by run_op during an operation.
    logic [3:0]  obs_a [4];
    logic [3:0]  obs_b [4];
    logic        obs_cin [4];
    logic        err_start;
    logic        busy_start;
    logic        busy_after;
    logic        done_after;

    logic [4:0]  t0;
    logic [4:0]  t1;

    always #5 clk = ~clk;

    // Behavioural single-digit BCD adders, one per instance.
    always_comb begin
        t0 = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_cin};
        if (t0 > 5'd9) begin
            dig_sum  = t0[3:0] + 4'd6;
            dig_cout = 1'b1;
        end else begin
            dig_sum  = t0[3:0];
            dig_cout = 1'b0;
        end
    end

    always_comb begin
        t1 = {1'b0, dig1_a} + {1'b0, dig1_b} + {4'd0, dig1_cin};
        if (t1 > 5'd9) begin
            dig1_sum  = t1[3:0] + 4'd6;
            dig1_cout = 1'b1;
        end else begin
            dig1_sum  = t1[3:0];
            dig1_cout = 1'b0;
        end
    end

    bcd_serial_add_ctrl #(.DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef BCD_SUB_EN
        .sub      (sub),
`endif
        .dig_a    (dig_a),
        .dig_b    (dig_b),
        .dig_cin  (dig_cin),
        .dig_sum  (dig_sum),
        .dig_cout (dig_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .err      (err)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .a        (a1),
        .b        (b1),
        .cin      (cin1),
`ifdef BCD_SUB_EN
        .sub      (1'b0),
`endif
        .dig_a    (dig1_a),
        .dig_b    (dig1_b),
        .dig_cin  (dig1_cin),
        .dig_sum  (dig1_sum),
        .dig_cout (dig1_cout),
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .cout     (cout1),
        .err      (err1)
    );

    // Starts one operation on the 4-digit instance and waits, with a bound,
    // for done. It then steps one more edge so that the instance is idle
    // again. olat is the number of edges from the start-sampling edge to done.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          output logic [15:0] osum, output logic ocout,
                          output logic oerr, output int olat);
        @(negedge clk);
        a = ia;
        b = ib;
        cin = ic;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        err_start  = err;
        busy_start = busy;
        olat = 0;
        while (done !== 1'b1 && olat < 20) begin
            if (olat < 4) begin
                obs_a[olat]   = dig_a;
                obs_b[olat]   = dig_b;
                obs_cin[olat] = dig_cin;
            end
            @(posedge clk);
            #1;
            olat++;
        end
        osum  = sum;
        ocout = cout;
        oerr  = err;
        @(posedge clk);
        #1;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cin1 = 1'b0;
`ifdef BCD_SUB_EN
        sub = 1'b0;
`endif
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_result: got sum=%h cout=%b err=%b expected 0000 0 0", sum, cout, err);
        end
        checks++;
        if (dig_a !== 4'd0 || dig_b !== 4'd0 || dig_cin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dig: got %h %h %b expected 0 0 0", dig_a, dig_b, dig_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic;
        logic [15:0] s;
        logic c;
        logic e;
        int l;
        run_op(16'h1234, 16'h5678, 1'b0, s, c, e, l);
        checks++;
        if (l !== 4) begin
            errors++;
            $display("[TB] FAIL add_latency: got %0d expected 4", l);
        end
        checks++;
        if (s !== 16'h6912 || c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_sum: got %h/%b expected 6912/0", s, c);
        end
        checks++;
        if (e !== 1'b0 || err_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_err: got %b/%b expected 0/0", err_start, e);
        end
        checks++;
        if (busy_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_busy_run: got %b expected 1", busy_start);
        end
        checks++;
        if (obs_a[0] !== 4'd4 || obs_b[0] !== 4'd8 || obs_cin[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_digit0: got %h %h %b expected 4 8 0", obs_a[0], obs_b[0], obs_cin[0]);
        end
        checks++;
        if (obs_a[1] !== 4'd3 || obs_b[1] !== 4'd7 || obs_cin[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_digit1: got %h %h %b expected 3 7 1", obs_a[1], obs_b[1], obs_cin[1]);
        end
        checks++;
        if (obs_a[3] !== 4'd1 || obs_b[3] !== 4'd5 || obs_cin[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_digit3: got %h %h %b expected 1 5 0", obs_a[3], obs_b[3], obs_cin[3]);
        end
        checks++;
        if (busy_after !== 1'b0 || done_after !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_after_done: got busy=%b done=%b expected 0 0", busy_after, done_after);
        end
        checks++;
        if (sum !== 16'h6912) begin
            errors++;
            $display("[TB] FAIL add_sum_held: got %h expected 6912", sum);
        end
    endtask

    task automatic test_carry;
        logic [15:0] s;
        logic c;
        logic e;
        int l;
        run_op(16'h9999, 16'h0001, 1'b0, s, c, e, l);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1) begin
            errors++;
            $display("[TB] FAIL carry_ripple: got %h/%b expected 0000/1", s, c);
        end
        run_op(16'h0000, 16'h0000, 1'b1, s, c, e, l);
        checks++;
        if (s !== 16'h0001 || c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry_in: got %h/%b expected 0001/0", s, c);
        end
    endtask

    task automatic test_err;
        logic [15:0] s;
        logic c;
        logic e;
        int l;
        run_op(16'h00A0, 16'h0000, 1'b0, s, c, e, l);
        checks++;
        if (err_start !== 1'b1 || e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_set: got %b/%b expected 1/1", err_start, e);
        end
        checks++;
        if (s !== 16'h0100 || c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_sum: got %h/%b expected 0100/0", s, c);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_held: got %b expected 1", err);
        end
        run_op(16'h0001, 16'h0000, 1'b0, s, c, e, l);
        checks++;
        if (err_start !== 1'b0 || s !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL err_clear: got err=%b sum=%h expected 0 0001", err_start, s);
        end
    endtask

    task automatic test_back_to_back;
        int ndone;
        int last;
        ndone = 0;
        last = -1;
        @(negedge clk);
        a = 16'h0005;
        b = 16'h0005;
        cin = 1'b0;
        start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 2) begin
                a = 16'h9999;
                b = 16'h9999;
            end
            if (n == 4) begin
                a = 16'h0005;
                b = 16'h0005;
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (sum !== 16'h0010 || cout !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_sum: got %h/%b expected 0010/0 at cycle %0d", sum, cout, n);
                end
                checks++;
                if (last < 0) begin
                    if (n !== 5) begin
                        errors++;
                        $display("[TB] FAIL b2b_first_done: got cycle %0d expected 5", n);
                    end
                end else if (n - last !== 6) begin
                    errors++;
                    $display("[TB] FAIL b2b_interval: got %0d expected 6", n - last);
                end
                last = n;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 4", ndone);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [15:0] s;
        logic c;
        logic e;
        int l;
        int seen;
        seen = 0;
        @(negedge clk);
        a = 16'h1234;
        b = 16'h5678;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, err, dig_cin, dig_a, dig_b, sum} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b dig=%h%h%b expected all 0",
                     busy, done, sum, cout, dig_a, dig_b, dig_cin);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d done cycles expected 0", seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0042, 16'h0058, 1'b0, s, c, e, l);
        checks++;
        if (s !== 16'h0100 || c !== 1'b0 || l !== 4) begin
            errors++;
            $display("[TB] FAIL midreset_recover: got %h/%b lat %0d expected 0100/0 lat 4", s, c, l);
        end
    endtask

    task automatic test_single_digit;
        @(negedge clk);
        a1 = 4'd8;
        b1 = 4'd5;
        cin1 = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        checks++;
        if (dig1_a !== 4'd8 || dig1_b !== 4'd5 || done1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL d1_run: got %h %h done=%b busy=%b expected 8 5 0 1", dig1_a, dig1_b, done1, busy1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b1 || sum1 !== 4'd3 || cout1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL d1_result: got done=%b %h/%b expected 1 3/1", done1, sum1, cout1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL d1_idle: got done=%b busy=%b expected 0 0", done1, busy1);
        end
        @(negedge clk);
        a1 = 4'd9;
        b1 = 4'd9;
        cin1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b1 || sum1 !== 4'd9 || cout1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL d1_max: got done=%b %h/%b expected 1 9/1", done1, sum1, cout1);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub;
        logic [15:0] s;
        logic c;
        logic e;
        int l;
        sub = 1'b1;
        run_op(16'h5000, 16'h1234, 1'b0, s, c, e, l);
        checks++;
        if (s !== 16'h3766 || c !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_pos: got %h/%b expected 3766/1", s, c);
        end
        checks++;
        if (obs_b[0] !== 4'd5 || obs_cin[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_digit0: got %h %b expected 5 1", obs_b[0], obs_cin[0]);
        end
        run_op(16'h1234, 16'h5000, 1'b0, s, c, e, l);
        checks++;
        if (s !== 16'h6234 || c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_neg: got %h/%b expected 6234/0", s, c);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add_basic();
        test_carry();
        test_err();
        test_back_to_back();
        test_reset_mid();
        test_single_digit();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
